// File: rtl/fwg_pkg.sv
// Shared types and constants for the DDS function generator.
package fwg_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } fwg_mode_e;

    // Cycles from a phase being captured to its sample appearing on data_out.
    localparam int unsigned FWG_LAT = 3;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table with registered output. It expands a quarter table to the full
// period: odd quadrants read the address mirrored, and the second half-period is negated.
module sine_quarter_rom #(
    parameter int DATA_W = 8,
    parameter int LUT_AW = 6
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [LUT_AW+1:0]        p,
    output logic signed [DATA_W-1:0] sample
);

    localparam int ENTRIES = 2 ** LUT_AW;

    // Entry k = round(peak * sin(pi/2 * (k + 0.5) / ENTRIES)). The half-step offset keeps every
    // entry non-zero and makes the quarter mirror exactly.
    function automatic logic [ENTRIES*DATA_W-1:0] build_rom();
        logic [ENTRIES*DATA_W-1:0] rom;
        real x, term, s, peak;
        int  v;
        rom  = '0;
        peak = real'((2 ** (DATA_W - 1)) - 1);
        for (int k = 0; k < ENTRIES; k++) begin
            x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(ENTRIES);
            s    = x;
            term = x;
            for (int n = 1; n < 10; n++) begin
                term = -term * x * x / real'((2 * n) * (2 * n + 1));
                s    = s + term;
            end
            v = $rtoi(peak * s + 0.5);
            rom[k*DATA_W +: DATA_W] = DATA_W'(v);
        end
        return rom;
    endfunction

    localparam logic [ENTRIES*DATA_W-1:0] ROM = build_rom();

    logic [1:0]               quad;
    logic [LUT_AW-1:0]        addr;
    logic signed [DATA_W-1:0] mag;

    // Quadrant decode and table read.
    always_comb begin
        quad = p[LUT_AW+1:LUT_AW];
        addr = quad[0] ? ~p[LUT_AW-1:0] : p[LUT_AW-1:0];
        mag  = ROM[int'(addr) * DATA_W +: DATA_W];
    end

    // Registered output, negated for quadrants 2 and 3.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sample <= '0;
        end else begin
            sample <= quad[1] ? -mag : mag;
        end
    end

endmodule

// File: rtl/func_wave_gen.sv
// DDS function generator: phase accumulator, wrap-synchronised config update, and a
// fixed-latency three-stage pipeline of phase capture, raw wave, then amplitude scaling.
module func_wave_gen
    import fwg_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 6
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               En,
    input  logic               Sync,
    input  logic               Cfg_valid,
    output logic               Cfg_ready,
    input  logic [1:0]         Cfg_mode,
    input  logic [PHASE_W-1:0] Cfg_ftw,
    input  logic [DATA_W:0]    Cfg_amp,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    output logic               Cycle_wrap
);

    // Phase bits carried into S1: enough for the ROM address and for the triangle slice.
    localparam int S1_W = (DATA_W + 1 > LUT_AW + 2) ? DATA_W + 1 : LUT_AW + 2;
    localparam int PR_W = 2 * DATA_W + 2;

    localparam logic [DATA_W:0]   AMP_UNITY = {1'b1, {DATA_W{1'b0}}};
    localparam logic [DATA_W-1:0] POS_FULL  = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_FULL  = {1'b1, {(DATA_W - 2){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] HALF      = {1'b1, {(DATA_W - 1){1'b0}}};

    // Accumulator state; wrap_q marks that the current phase value starts a new period.
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W:0]   sum;
    logic               add_wrap;

    // Active and pending configuration.
    fwg_mode_e          act_mode_q, act_mode_d, pend_mode_q, pend_mode_d;
    logic [PHASE_W-1:0] act_ftw_q, act_ftw_d, pend_ftw_q, pend_ftw_d;
    logic [DATA_W:0]    act_amp_q, act_amp_d, pend_amp_q, pend_amp_d;
    logic               pend_valid_q, pend_valid_d;
    logic               accept;
    logic [DATA_W:0]    cfg_amp_clamped;

    // Pipeline.
    logic [S1_W-1:0]          s1_ph_q;
    fwg_mode_e                s1_mode_q, s2_mode_q;
    logic [DATA_W:0]          s1_amp_q, s2_amp_q;
    logic [FWG_LAT-1:0]       v_q, wr_q;
    logic [DATA_W-1:0]        arith_w, s2_arith_q;
    logic signed [DATA_W-1:0] rom_sample;
    logic [DATA_W-1:0]        wave;
    logic signed [PR_W-1:0]   prod;
    logic                     unused_prod;

    assign Cfg_ready       = ~pend_valid_q;
    assign accept          = Cfg_valid & Cfg_ready;
    assign cfg_amp_clamped = (Cfg_amp > AMP_UNITY) ? AMP_UNITY : Cfg_amp;
    assign sum             = {1'b0, phase_q} + {1'b0, act_ftw_q};
    assign add_wrap        = En & sum[PHASE_W];

    // Next phase: Sync restarts at zero and counts as a wrap; the flag holds while paused.
    always_comb begin
        phase_d = phase_q;
        wrap_d  = wrap_q;
        if (Sync) begin
            phase_d = '0;
            wrap_d  = 1'b1;
        end else if (En) begin
            phase_d = sum[PHASE_W-1:0];
            wrap_d  = sum[PHASE_W];
        end
    end

    // Config slot: accept into pending, apply on wrap, pause or Sync.
    always_comb begin
        act_mode_d   = act_mode_q;
        act_ftw_d    = act_ftw_q;
        act_amp_d    = act_amp_q;
        pend_mode_d  = pend_mode_q;
        pend_ftw_d   = pend_ftw_q;
        pend_amp_d   = pend_amp_q;
        pend_valid_d = pend_valid_q;
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = fwg_mode_e'(Cfg_mode);
            pend_ftw_d   = Cfg_ftw;
            pend_amp_d   = cfg_amp_clamped;
        end
        if (Sync) begin
            if (accept) begin
                // Offer coinciding with Sync bypasses the slot.
                act_mode_d   = fwg_mode_e'(Cfg_mode);
                act_ftw_d    = Cfg_ftw;
                act_amp_d    = cfg_amp_clamped;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_mode_d   = pend_mode_q;
                act_ftw_d    = pend_ftw_q;
                act_amp_d    = pend_amp_q;
                pend_valid_d = 1'b0;
            end
        end else if (pend_valid_q && (!En || add_wrap)) begin
            act_mode_d   = pend_mode_q;
            act_ftw_d    = pend_ftw_q;
            act_amp_d    = pend_amp_q;
            pend_valid_d = 1'b0;
        end
    end

    // Accumulator and configuration registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            phase_q      <= '0;
            wrap_q       <= 1'b0;
            act_mode_q   <= MODE_SINE;
            act_ftw_q    <= '0;
            act_amp_q    <= AMP_UNITY;
            pend_mode_q  <= MODE_SINE;
            pend_ftw_q   <= '0;
            pend_amp_q   <= AMP_UNITY;
            pend_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            wrap_q       <= wrap_d;
            act_mode_q   <= act_mode_d;
            act_ftw_q    <= act_ftw_d;
            act_amp_q    <= act_amp_d;
            pend_mode_q  <= pend_mode_d;
            pend_ftw_q   <= pend_ftw_d;
            pend_amp_q   <= pend_amp_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // S2 arithmetic waves from the captured phase.
    always_comb begin
        arith_w = '0;
        unique case (s1_mode_q)
            MODE_SQUARE: arith_w = s1_ph_q[S1_W-1] ? NEG_FULL : POS_FULL;
            MODE_SAW:    arith_w = {~s1_ph_q[S1_W-1], s1_ph_q[S1_W-2 -: DATA_W-1]};
            MODE_TRI:    arith_w = s1_ph_q[S1_W-1] ? (POS_FULL - s1_ph_q[S1_W-2 -: DATA_W])
                                                   : (s1_ph_q[S1_W-2 -: DATA_W] - HALF);
            default:     arith_w = '0;
        endcase
    end

    sine_quarter_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .p      (s1_ph_q[S1_W-1 -: LUT_AW+2]),
        .sample (rom_sample)
    );

    // S3 scaling: signed wave times unsigned amp, floor-shifted back to DATA_W.
    always_comb begin
        wave = (s2_mode_q == MODE_SINE) ? rom_sample : s2_arith_q;
        prod = $signed({{(DATA_W + 2){wave[DATA_W-1]}}, wave})
             * $signed({{(DATA_W + 1){1'b0}}, s2_amp_q});
    end

    assign unused_prod = ^{prod[PR_W-1:2*DATA_W], prod[DATA_W-1:0]};

    // Pipeline registers; data_out only moves when a valid sample arrives.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_ph_q    <= '0;
            s1_mode_q  <= MODE_SINE;
            s1_amp_q   <= '0;
            s2_mode_q  <= MODE_SINE;
            s2_amp_q   <= '0;
            s2_arith_q <= '0;
            v_q        <= '0;
            wr_q       <= '0;
            data_out   <= '0;
        end else begin
            s1_ph_q    <= phase_q[PHASE_W-1 -: S1_W];
            s1_mode_q  <= act_mode_q;
            s1_amp_q   <= act_amp_q;
            s2_mode_q  <= s1_mode_q;
            s2_amp_q   <= s1_amp_q;
            s2_arith_q <= arith_w;
            v_q        <= {v_q[FWG_LAT-2:0], En};
            wr_q       <= {wr_q[FWG_LAT-2:0], wrap_q};
            if (v_q[FWG_LAT-2]) begin
                data_out <= prod[2*DATA_W-1:DATA_W];
            end
        end
    end

    assign data_valid = v_q[FWG_LAT-1];
    assign Cycle_wrap = wr_q[FWG_LAT-1] & v_q[FWG_LAT-1];

endmodule

// File: tb/tb_func_wave_gen.sv
// Directed bench for func_wave_gen with DATA_W=8, PHASE_W=24, LUT_AW=6.
module tb_func_wave_gen;
    import fwg_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        En;
    logic        Sync;
    logic        Cfg_valid;
    logic        Cfg_ready;
    logic [1:0]  Cfg_mode;
    logic [23:0] Cfg_ftw;
    logic [8:0]  Cfg_amp;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        Cycle_wrap;

    int n_checks = 0;
    int n_pass   = 0;

    func_wave_gen #(
        .DATA_W  (8),
        .PHASE_W (24),
        .LUT_AW  (6)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .En         (En),
        .Sync       (Sync),
        .Cfg_valid  (Cfg_valid),
        .Cfg_ready  (Cfg_ready),
        .Cfg_mode   (Cfg_mode),
        .Cfg_ftw    (Cfg_ftw),
        .Cfg_amp    (Cfg_amp),
        .data_out   (data_out),
        .data_valid (data_valid),
        .Cycle_wrap (Cycle_wrap)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; En = 1'b0; Sync = 1'b0; Cfg_valid = 1'b0;
        Cfg_mode = 2'd0; Cfg_ftw = '0; Cfg_amp = '0;
        tick(); tick();
        Rst_n = 1'b1;
    endtask

    // Offer while paused; the next paused edge applies it. Phase is left untouched.
    task automatic load_cfg(input logic [1:0] mode, input logic [23:0] ftw, input logic [8:0] amp);
        En = 1'b0; Cfg_valid = 1'b1; Cfg_mode = mode; Cfg_ftw = ftw; Cfg_amp = amp;
        tick();
        Cfg_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; En = 1'b0; Sync = 1'b0; Cfg_valid = 1'b0;
        Cfg_mode = 2'd0; Cfg_ftw = '0; Cfg_amp = '0;
        #1;
        n_checks++;
        if (data_out !== 8'd0) $display("FAIL reset_data_out: got %0d want 0", data_out);
        else n_pass++;
        n_checks++;
        if (data_valid !== 1'b0 || Cycle_wrap !== 1'b0 || Cfg_ready !== 1'b1)
            $display("FAIL reset_flags: valid=%b wrap=%b ready=%b want 0 0 1",
                     data_valid, Cycle_wrap, Cfg_ready);
        else n_pass++;

        do_reset();
        load_cfg(MODE_SAW, 24'h010000, 9'd256);
        En = 1'b1;
        repeat (10) tick();
        Cfg_valid = 1'b1; Cfg_mode = MODE_TRI; Cfg_ftw = 24'h010000; Cfg_amp = 9'd256;
        tick();
        Cfg_valid = 1'b0;
        n_checks++;
        if (Cfg_ready !== 1'b0) $display("FAIL reset_pending_ready: got %b want 0", Cfg_ready);
        else n_pass++;
        tick();
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 8'd0 || data_valid !== 1'b0 || Cfg_ready !== 1'b1)
            $display("FAIL reset_midstream: data=%0d valid=%b ready=%b want 0 0 1",
                     data_out, data_valid, Cfg_ready);
        else n_pass++;
        tick();
        Rst_n = 1'b1;
        En    = 1'b1;
        repeat (3) tick();
        // Default config is sine with ftw=0, so the k=0 entry repeats.
        n_checks++;
        if (data_valid !== 1'b1 || $signed(data_out) !== 8'sd2)
            $display("FAIL reset_default_cfg: valid=%b data=%0d want 1 2",
                     data_valid, $signed(data_out));
        else n_pass++;
        repeat (5) tick();
        n_checks++;
        if ($signed(data_out) !== 8'sd2 || Cycle_wrap !== 1'b0)
            $display("FAIL reset_ftw_zero: data=%0d wrap=%b want 2 0",
                     $signed(data_out), Cycle_wrap);
        else n_pass++;
    endtask

    // Continues from test_reset: sine, ftw=0, En=1.
    task automatic test_ftw_zero();
        Cfg_valid = 1'b1; Cfg_mode = MODE_SQUARE; Cfg_ftw = 24'h020000; Cfg_amp = 9'd256;
        tick();
        Cfg_valid = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (Cfg_ready !== 1'b0 || $signed(data_out) !== 8'sd2)
            $display("FAIL ftw0_pending_waits: ready=%b data=%0d want 0 2",
                     Cfg_ready, $signed(data_out));
        else n_pass++;
        En = 1'b0;
        tick();
        n_checks++;
        if (Cfg_ready !== 1'b1) $display("FAIL ftw0_pause_apply: ready=%b want 1", Cfg_ready);
        else n_pass++;
        En = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (data_valid !== 1'b1 || $signed(data_out) !== 8'sd127)
            $display("FAIL ftw0_square_after_apply: valid=%b data=%0d want 1 127",
                     data_valid, $signed(data_out));
        else n_pass++;
    endtask

    task automatic test_saw();
        logic signed [7:0] exp;
        logic              exp_wrap;
        do_reset();
        load_cfg(MODE_SAW, 24'h010000, 9'd256);
        En = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_checks++;
            if (data_valid !== 1'b0) $display("FAIL saw_valid_early[%0d]: got %b want 0", c, data_valid);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (data_valid !== 1'b1) $display("FAIL saw_valid_cycle3: got %b want 1", data_valid);
        else n_pass++;
        for (int n = 0; n < 260; n++) begin
            exp      = 8'(n) ^ 8'h80;
            exp_wrap = (n > 0) && (n % 256 == 0);
            n_checks++;
            if ($signed(data_out) !== exp || Cycle_wrap !== exp_wrap)
                $display("FAIL saw_sample[%0d]: data=%0d wrap=%b want %0d %b",
                         n, $signed(data_out), Cycle_wrap, exp, exp_wrap);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_square();
        logic signed [7:0] exp;
        do_reset();
        load_cfg(MODE_SQUARE, 24'h020000, 9'd128);
        En = 1'b1;
        repeat (3) tick();
        for (int n = 0; n < 130; n++) begin
            exp = ((n % 128) < 64) ? 8'sd63 : -8'sd64;
            n_checks++;
            if ($signed(data_out) !== exp)
                $display("FAIL square_half_amp[%0d]: got %0d want %0d", n, $signed(data_out), exp);
            else n_pass++;
            tick();
        end

        do_reset();
        load_cfg(MODE_SQUARE, 24'h020000, 9'd0);
        En = 1'b1;
        repeat (3) tick();
        for (int n = 0; n < 128; n += 8) begin
            n_checks++;
            if (data_out !== 8'd0 || data_valid !== 1'b1)
                $display("FAIL square_amp0[%0d]: data=%0d valid=%b want 0 1",
                         n, $signed(data_out), data_valid);
            else n_pass++;
            repeat (8) tick();
        end

        // Oversized amp is clamped to unity.
        do_reset();
        load_cfg(MODE_SQUARE, 24'h020000, 9'h1FF);
        En = 1'b1;
        repeat (3) tick();
        for (int n = 0; n < 128; n++) begin
            exp = (n < 64) ? 8'sd127 : -8'sd127;
            n_checks++;
            if ($signed(data_out) !== exp)
                $display("FAIL square_amp_clamp[%0d]: got %0d want %0d", n, $signed(data_out), exp);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mid_cfg();
        logic signed [7:0] exp;
        logic [7:0]        q;
        int                n;
        int                m;
        do_reset();
        load_cfg(MODE_SAW, 24'h010000, 9'd256);
        En = 1'b1;
        for (int e = 1; e <= 410; e++) begin
            Cfg_valid = (e == 65);
            if (e == 65) begin
                // Phase is 0x400000 here.
                Cfg_mode = MODE_TRI; Cfg_ftw = 24'h010000; Cfg_amp = 9'd256;
                n_checks++;
                if (Cfg_ready !== 1'b1) $display("FAIL mid_ready_before: got %b want 1", Cfg_ready);
                else n_pass++;
            end
            tick();
            if (e == 65 || e == 255) begin
                n_checks++;
                if (Cfg_ready !== 1'b0) $display("FAIL mid_ready_low[%0d]: got %b want 0", e, Cfg_ready);
                else n_pass++;
            end
            if (e == 256) begin
                n_checks++;
                if (Cfg_ready !== 1'b1) $display("FAIL mid_ready_at_wrap: got %b want 1", Cfg_ready);
                else n_pass++;
            end
            n = e - 3;
            if (n >= 250 && n <= 400) begin
                if (n < 256) begin
                    exp = 8'(n) ^ 8'h80;
                end else begin
                    m   = n - 256;
                    q   = {7'(m), 1'b0};
                    exp = (m >= 128) ? 8'(127 - int'(q)) : 8'(int'(q) - 128);
                end
                n_checks++;
                if ($signed(data_out) !== exp)
                    $display("FAIL mid_sample[%0d]: got %0d want %0d", n, $signed(data_out), exp);
                else n_pass++;
            end
            if (n == 255 || n == 256) begin
                n_checks++;
                if (Cycle_wrap !== (n == 256))
                    $display("FAIL mid_cycle_wrap[%0d]: got %b want %b", n, Cycle_wrap, n == 256);
                else n_pass++;
            end
        end
        Cfg_valid = 1'b0;
    endtask

    task automatic test_sync();
        logic signed [7:0] exp_seq [5];
        exp_seq = '{8'sd2, 8'sd50, 8'sd91, 8'sd118, 8'sd127};
        do_reset();
        load_cfg(MODE_SAW, 24'h010000, 9'd256);
        En = 1'b1;
        repeat (10) tick();
        Cfg_valid = 1'b1; Cfg_mode = MODE_SINE; Cfg_ftw = 24'h100000; Cfg_amp = 9'd256;
        tick();
        Cfg_valid = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (Cfg_ready !== 1'b0) $display("FAIL sync_pending_ready: got %b want 0", Cfg_ready);
        else n_pass++;
        Sync = 1'b1;
        tick();
        Sync = 1'b0;
        n_checks++;
        if (Cfg_ready !== 1'b1) $display("FAIL sync_ready_after: got %b want 1", Cfg_ready);
        else n_pass++;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ($signed(data_out) !== exp_seq[i] || Cycle_wrap !== (i == 0) || data_valid !== 1'b1)
                $display("FAIL sync_sine[%0d]: data=%0d wrap=%b valid=%b want %0d %b 1",
                         i, $signed(data_out), Cycle_wrap, data_valid, exp_seq[i], i == 0);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_sine_sym();
        logic signed [7:0] s [256];
        logic signed [7:0] mx;
        int                zeros;
        int                idx [8];
        logic signed [7:0] val [8];
        idx = '{0, 16, 32, 48, 63, 64, 128, 191};
        val = '{8'sd2, 8'sd50, 8'sd91, 8'sd118, 8'sd127, 8'sd127, -8'sd2, -8'sd127};
        do_reset();
        load_cfg(MODE_SINE, 24'h010000, 9'd256);
        En = 1'b1;
        repeat (3) tick();
        for (int n = 0; n < 256; n++) begin
            s[n] = $signed(data_out);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (s[idx[i]] !== val[i])
                $display("FAIL sine_value[%0d]: got %0d want %0d", idx[i], s[idx[i]], val[i]);
            else n_pass++;
        end
        for (int n = 0; n < 128; n++) begin
            n_checks++;
            if (s[n] !== -s[n+128])
                $display("FAIL sine_antisym[%0d]: got %0d want %0d", n, s[n], -s[n+128]);
            else n_pass++;
        end
        for (int n = 0; n < 64; n++) begin
            n_checks++;
            if (s[n] !== s[127-n])
                $display("FAIL sine_mirror[%0d]: got %0d want %0d", n, s[n], s[127-n]);
            else n_pass++;
        end
        mx    = -8'sd128;
        zeros = 0;
        for (int n = 0; n < 256; n++) begin
            if (s[n] > mx) mx = s[n];
            if (s[n] == 8'sd0) zeros++;
        end
        n_checks++;
        if (mx !== 8'sd127) $display("FAIL sine_peak: got %0d want 127", mx);
        else n_pass++;
        n_checks++;
        if (zeros != 0) $display("FAIL sine_no_zero: got %0d zero samples want 0", zeros);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ftw_zero();
        test_saw();
        test_square();
        test_mid_cfg();
        test_sync();
        test_sine_sym();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
